// File: rtl/enc_mac_seq.sv
// Control sequencer for the shared 6-lane MAC datapath: issues one element per cycle,
// drains the product pipeline, captures the accumulators and holds them until downstream accepts.
module enc_mac_seq #(
  parameter int BITSIZE = 20,
  parameter int LANES   = 6,
  parameter int MAX_IN  = 10,
  parameter int IDXW    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [IDXW-1:0]            n_in,
  output logic                       busy,
  output logic                       err,
  output logic [IDXW-1:0]            idx,
  output logic                       mul_en,
  output logic                       acc_load_bias,
  output logic                       acc_en,
  input  logic [BITSIZE*LANES-1:0]   acc_in,
  output logic [BITSIZE*LANES-1:0]   y,
  output logic                       y_valid,
  input  logic                       y_ready
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_CAPTURE, S_HOLD} state_t;

  localparam logic [IDXW-1:0] MAX_IN_W = IDXW'(MAX_IN);

  state_t                     state_q, state_d;
  logic [IDXW-1:0]            n_q, n_d;
  logic [IDXW-1:0]            k_q, k_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic                       busy_q, busy_d;
  logic                       err_q, err_d;
  logic                       mul_en_q, mul_en_d;
  logic                       bias_q, bias_d;
  logic                       acc_en_q, acc_en_d;
  logic [BITSIZE*LANES-1:0]   y_q, y_d;
  logic                       y_valid_q, y_valid_d;
  logic                       len_ok;

  assign len_ok = (n_in != '0) && (n_in <= MAX_IN_W);

  // Strobes are computed for the state being entered so that every output is a flop.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    k_d       = k_q;
    idx_d     = idx_q;
    err_d     = 1'b0;
    mul_en_d  = 1'b0;
    bias_d    = 1'b0;
    acc_en_d  = 1'b0;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start) begin
          if (len_ok) begin
            n_d      = n_in;
            k_d      = '0;
            mul_en_d = 1'b1;
            bias_d   = 1'b1;
            state_d  = S_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        acc_en_d = 1'b1;
        if (k_q == n_q - 1'b1) begin
          state_d = S_DRAIN;
        end else begin
          k_d      = k_q + 1'b1;
          idx_d    = k_q + 1'b1;
          mul_en_d = 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        y_d       = acc_in;
        y_valid_d = 1'b1;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        if (y_valid_q && y_ready) begin
          y_valid_d = 1'b0;
          idx_d     = '0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      k_q       <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      mul_en_q  <= 1'b0;
      bias_q    <= 1'b0;
      acc_en_q  <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      k_q       <= k_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      mul_en_q  <= mul_en_d;
      bias_q    <= bias_d;
      acc_en_q  <= acc_en_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign busy          = busy_q;
  assign err           = err_q;
  assign idx           = idx_q;
  assign mul_en        = mul_en_q;
  assign acc_load_bias = bias_q;
  assign acc_en        = acc_en_q;
  assign y             = y_q;
  assign y_valid       = y_valid_q;

endmodule

// File: tb/tb_enc_mac_seq.sv
// Bench for enc_mac_seq: behavioural MAC datapath, directed jobs, scoreboard checked on each handshake.
module tb_enc_mac_seq;

  localparam int BS = 20;
  localparam int L  = 6;
  localparam int W  = BS * L;

  logic          clk = 1'b0;
  logic          reset, start, y_ready;
  logic [3:0]    n_in;
  logic          busy, err, mul_en, acc_load_bias, acc_en, y_valid;
  logic [3:0]    idx;
  logic [W-1:0]  acc_in, y;

  enc_mac_seq #(.BITSIZE(BS), .LANES(L), .MAX_IN(10), .IDXW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .n_in(n_in),
    .busy(busy), .err(err), .idx(idx), .mul_en(mul_en),
    .acc_load_bias(acc_load_bias), .acc_en(acc_en), .acc_in(acc_in),
    .y(y), .y_valid(y_valid), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural datapath following the product/accumulator contract.
  int xt[10];
  int wt[10][L];
  int bt[L];
  logic [BS-1:0] prod[L];
  logic [BS-1:0] acc[L];

  initial begin
    for (int l = 0; l < L; l++) begin
      prod[l] = '0;
      acc[l]  = '0;
    end
  end

  always @(posedge clk) begin
    for (int l = 0; l < L; l++) begin
      if (mul_en && idx < 4'd10) prod[l] <= BS'(xt[idx] * wt[idx][l]);
      if (acc_load_bias) acc[l] <= BS'(bt[l]);
      else if (acc_en)   acc[l] <= acc[l] + prod[l];
    end
  end

  always @* begin
    for (int l = 0; l < L; l++) acc_in[l*BS +: BS] = acc[l];
  end

  task automatic set_tab(input int mode);
    for (int i = 0; i < 10; i++)
      for (int l = 0; l < L; l++) begin
        case (mode)
          0: begin xt[i] = i + 1; wt[i][l] = l + 1; bt[l] = l;   end
          1: begin xt[i] = (i == 0) ? 2 : 0; wt[i][l] = 3; bt[l] = 5; end
          2: begin xt[i] = i + 1; wt[i][l] = 3; bt[l] = 1;       end
          default: begin xt[i] = 2; wt[i][l] = l + 2; bt[l] = 100; end
        endcase
      end
  endtask

  typedef struct {
    logic [W-1:0] y;
    int           nacc;
  } exp_t;
  exp_t sb[$];

  task automatic push(input logic [W-1:0] ey, input int nacc);
    exp_t e;
    e.y = ey;
    e.nacc = nacc;
    sb.push_back(e);
  endtask

  // Monitor: counts acc_en strobes per job and checks y on every handshake.
  int acc_cnt = 0;
  always @(negedge clk) begin
    if (acc_load_bias) acc_cnt = 0;
    if (acc_en) acc_cnt++;
    if (y_valid && y_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_y_valid", y_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("y_result", y, e.y);
        chk("acc_en_count", acc_cnt, e.nacc);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int n);
    start = 1'b1;
    n_in  = 4'(n);
    nxt();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 40 && busy; i++) nxt();
    chk(nm, busy, 0);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_strobes"}, {mul_en, acc_load_bias, acc_en}, 0);
    chk({nm, "_idx"}, idx, 0);
    chk({nm, "_y_valid"}, y_valid, 0);
  endtask

  logic [W-1:0] e;

  initial begin
    reset = 1'b1; start = 1'b0; n_in = '0; y_ready = 1'b1;
    set_tab(0);
    nxt(); nxt();
    chk_quiet("reset");
    chk("reset_err", err, 0);
    chk("reset_y", y, 0);
    reset = 1'b0;
    nxt();

    // n=10, ready held high
    for (int l = 0; l < L; l++) e[l*BS +: BS] = BS'(55 * (l + 1) + l);
    push(e, 10);
    go(10);
    for (int c = 1; c <= 10; c++) begin
      chk("t1_idx", idx, c - 1);
      chk("t1_mul_en", mul_en, 1);
      chk("t1_bias", acc_load_bias, c == 1);
      chk("t1_acc_en", acc_en, c > 1);
      chk("t1_busy", busy, 1);
      nxt();
    end
    chk("t1_drain", {mul_en, acc_load_bias, acc_en}, 3'b001);
    chk("t1_drain_idx", idx, 9);
    nxt();
    chk("t1_capture", {mul_en, acc_load_bias, acc_en, y_valid}, 0);
    nxt();
    chk("t1_valid", y_valid, 1);
    chk("t1_y", y, e);
    nxt();
    chk("t1_valid_one_cycle", y_valid, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_idx", idx, 0);
    chk("t1_y_kept", y, e);

    // n=1: 2*3+5 = 11 per lane
    set_tab(1);
    for (int l = 0; l < L; l++) e[l*BS +: BS] = BS'(11);
    push(e, 1);
    go(1);
    chk("t2_c1", {mul_en, acc_load_bias, acc_en}, 3'b110);
    nxt();
    chk("t2_c2", {mul_en, acc_load_bias, acc_en}, 3'b001);
    nxt();
    chk("t2_c3_valid", y_valid, 0);
    nxt();
    chk("t2_c4_valid", y_valid, 1);
    chk("t2_y", y, e);
    nxt();

    // rejected lengths
    for (int t = 0; t < 3; t++) begin
      go((t == 0) ? 0 : (t == 1) ? 11 : 15);
      chk("rej_err", err, 1);
      chk_quiet("rej");
      nxt();
      chk("rej_err_pulse", err, 0);
      chk_quiet("rej2");
    end

    // n=4, ready held low: 10*3+1 = 31
    set_tab(2);
    y_ready = 1'b0;
    for (int l = 0; l < L; l++) e[l*BS +: BS] = BS'(31);
    push(e, 4);
    go(4);
    for (int c = 1; c < 7; c++) nxt();
    for (int c = 0; c < 20; c++) begin
      chk("hold_valid", y_valid, 1);
      chk("hold_y", y, e);
      chk("hold_busy", busy, 1);
      chk("hold_err", err, 0);
      chk("hold_strobes", {mul_en, acc_load_bias, acc_en}, 0);
      start = (c == 5 || c == 12);
      n_in  = 4'd2;
      nxt();
    end
    start = 1'b0;
    y_ready = 1'b1;
    nxt();
    chk("hold_released", busy, 0);
    chk("hold_valid_clear", y_valid, 0);
    for (int l = 0; l < L; l++) e[l*BS +: BS] = BS'(19);
    push(e, 3);
    go(3);
    chk("after_hold_accept", busy, 1);
    chk("after_hold_bias", acc_load_bias, 1);
    wait_done("after_hold_done");

    // reset mid-job
    set_tab(0);
    go(10);
    for (int c = 1; c < 5; c++) nxt();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    chk_quiet("midreset");
    chk("midreset_err", err, 0);
    chk("midreset_y", y, 0);
    for (int c = 0; c < 20; c++) nxt();
    chk("midreset_no_valid", y_valid, 0);

    // reset wins over start
    reset = 1'b1; start = 1'b1; n_in = 4'd3;
    nxt();
    reset = 1'b0; start = 1'b0;
    chk_quiet("rst_start");

    // back-to-back n=10 then n=6
    for (int l = 0; l < L; l++) e[l*BS +: BS] = BS'(55 * (l + 1) + l);
    push(e, 10);
    go(10);
    for (int i = 0; i < 40 && !y_valid; i++) nxt();
    chk("b2b_first_valid", y_valid, 1);
    nxt();
    set_tab(3);
    for (int l = 0; l < L; l++) e[l*BS +: BS] = BS'(12 * (l + 2) + 100);
    push(e, 6);
    go(6);
    chk("b2b_second_accept", busy, 1);
    wait_done("b2b_done");
    nxt();

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/enc_mac_seq.md
# enc_mac_seq

Sequencer for the 6-lane fixed-point multiply/accumulate datapath used by the encoder layers. It replaces a free-running iteration counter with an explicit start/done protocol and drives the datapath's control inputs: column index, product-register enable, bias load and accumulate enable. The input length is set per job at run time. Each finished 6-lane result vector is captured and held until a downstream ready/valid handshake completes. The block sits between the layer scheduler (which issues `start`) and one shared MAC datapath instance.

## Interface
- `BITSIZE`, 20: width of one fixed-point element.
- `LANES`, 6: number of parallel MAC lanes; sets the result-vector width.
- `MAX_IN`, 10: maximum input-vector length per job.
- `IDXW`, 4: width of `idx` and `n_in`; must satisfy 2^IDXW > MAX_IN.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: job request; sampled only in IDLE.
- `n_in` in IDXW: input length for the job; sampled together with `start`.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle pulse when a job request is rejected.
- `idx` out IDXW: datapath selects x[idx] and weight row idx.
- `mul_en` out 1: datapath registers the current lane products.
- `acc_load_bias` out 1: datapath loads its accumulators with the bias vector.
- `acc_en` out 1: datapath adds the registered products into its accumulators.
- `acc_in` in BITSIZE*LANES: accumulator contents returned by the datapath.
- `y` out BITSIZE*LANES: captured result vector.
- `y_valid` out 1: `y` is valid.
- `y_ready` in 1: downstream accepts `y`.

## Operation
- Required datapath contract, per cycle:
  - product register: loads when `mul_en`=1;
  - accumulator: `acc <= acc_load_bias ? b : (acc_en ? acc + prod_reg : acc)`.
- States: IDLE, ISSUE, DRAIN, CAPTURE, HOLD.
- IDLE, on `start`=1:
  - If 1 <= `n_in` <= MAX_IN: latch `n_in` into `n_reg`, clear the counter `k`, go to ISSUE.
  - Otherwise (`n_in`=0 or `n_in`>MAX_IN): pulse `err` for one cycle and stay in IDLE.
- ISSUE (one cycle per element, k = 0 .. n_reg-1):
  - `idx`=k and `mul_en`=1.
  - `acc_load_bias`=1 only when k=0.
  - `acc_en`=1 when k>=1.
  - When k=n_reg-1, go to DRAIN; otherwise k increments.
- DRAIN, one cycle: `acc_en`=1, `mul_en`=0, `idx` holds n_reg-1.
- CAPTURE, one cycle: `y <= acc_in`, set `y_valid`, go to HOLD.
- HOLD:
  - `y` and `y_valid` stay stable.
  - When `y_valid`&&`y_ready`: clear `y_valid` and go to IDLE. `y` keeps its last value.
- Outputs outside ISSUE/DRAIN:
  - `mul_en`, `acc_load_bias` and `acc_en` are 0.
  - `idx` is 0 in IDLE and holds its last value in CAPTURE/HOLD.
- `acc_load_bias` and `acc_en` are never high in the same cycle.
- Exactly n_reg `acc_en` cycles occur per job.
- No data arithmetic is done in this block; `y` is a bit-exact copy of `acc_in`.

## Timing
- Reset values: state IDLE; `busy`, `err`, `mul_en`, `acc_load_bias`, `acc_en`, `y_valid` all 0; `idx`=0; `y`=0.
- Cycle numbering: `start` sampled in IDLE at edge 0.
  - ISSUE occupies cycles 1..n.
  - DRAIN is cycle n+1.
  - CAPTURE samples `acc_in` in cycle n+2.
  - `y_valid` is high from cycle n+3.
  - Latency is n+3 cycles: 13 for n=10, 4 for n=1.
- `busy` rises in cycle 1 and falls in the cycle after the handshake edge.
- `err` rises in cycle 1 for a rejected request.
- `start` while `busy`=1 is ignored: no `err` pulse, no effect on the running job.
- `y_ready` held high before CAPTURE: the handshake completes on the first edge with `y_valid`=1, so `y_valid` is high for exactly one cycle.
- `y_ready`=0 indefinitely: HOLD persists and `y` is unchanged.
- Back-to-back jobs: the earliest next `start` is sampled in the cycle after the handshake, in IDLE.
- `reset` asserted in any state:
  - Next edge returns all registers to their reset values.
  - The in-flight job is discarded and no `y_valid` is produced.
- `reset` and `start` together: `reset` wins.

## Test plan
- `n_in`=10, `start` pulse, `y_ready`=1 → expected response:
  - `idx` sequence 0..9 in cycles 1..10;
  - `acc_load_bias` only in cycle 1;
  - `acc_en` in cycles 2..11;
  - `y` equals `acc_in` from cycle 12, with `y_valid` in cycle 13 only.
- `n_in`=1 → `mul_en`+`acc_load_bias` in cycle 1, `acc_en` in cycle 2, `y_valid` at cycle 4.
  - With the behavioural datapath, x0=2, w0=3, b=5 gives 11 on every lane.
- `n_in`=0 and `n_in`=11 → one-cycle `err` pulse, `busy` stays 0, no control strobes.
- `n_in`=4 with `y_ready` held 0 for 20 cycles:
  - `y_valid` and `y` are stable throughout;
  - `start` pulses during HOLD are ignored;
  - raising `y_ready` completes the handshake, and a new `start` on the next cycle is accepted.
- `reset` asserted in cycle 5 of an `n_in`=10 job → the next cycle shows all outputs 0 and IDLE; no `y_valid` appears; a fresh job afterwards completes normally.
- Two back-to-back jobs (`n_in`=10, then 6), each with a different behavioural-datapath stimulus so the expected results differ → each `y` matches its own job's expected sum, and `acc_en` counts are 10 and 6.
